// File: rtl/pe_top_if.sv
// Internal bus between the PE sequencer and its fetch/storage unit:
// instruction fetch, operand row/column reads and the single result write port.
interface pe_top_if #(
  parameter int DW     = 32,
  parameter int N      = 4,
  parameter int IDEPTH = 32,
  parameter int IW     = 16
);
  localparam int AW  = $clog2(IDEPTH);
  localparam int IXW = $clog2(N);

  logic [AW-1:0]        pc;
  logic [IW-1:0]        inst;
  logic [IXW-1:0]       rd_i;
  logic [IXW-1:0]       rd_j;
  logic [N-1:0][DW-1:0] a_row;
  logic [N-1:0][DW-1:0] b_col;
  logic                 wr_en;
  logic                 clr;
  logic [IXW-1:0]       wr_i;
  logic [IXW-1:0]       wr_j;
  logic [DW-1:0]        wr_data;

  modport master (
    output pc, rd_i, rd_j, wr_en, clr, wr_i, wr_j, wr_data,
    input  inst, a_row, b_col
  );
  modport slave (
    input  pc, rd_i, rd_j, wr_en, clr, wr_i, wr_j, wr_data,
    output inst, a_row, b_col
  );
endinterface

// File: rtl/pe_top.sv
// 4-lane SIMD matrix PE: sequencer, per-lane multipliers, adder tree and the
// fetch/storage unit holding A, B, instruction memory and the result matrix.

module pe_lane #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] p
);
  assign p = a * b;
endmodule

module pe_fetch #(
  parameter int DW     = 32,
  parameter int N      = 4,
  parameter int IDEPTH = 32,
  parameter int IW     = 16
) (
  input  logic      clk,
  input  logic      rst,
  pe_top_if.slave   mem
);
  // Operand and instruction memories are preloaded hierarchically and never reset.
  logic [N-1:0][DW-1:0] ram_a      [N];
  logic [N-1:0][DW-1:0] ram_b      [N];
  logic [N-1:0][DW-1:0] ram_result [N];
  logic [IW-1:0]        ram_inst   [IDEPTH];

  assign mem.inst  = ram_inst[mem.pc];
  assign mem.a_row = ram_a[mem.rd_i];

  for (genvar k = 0; k < N; k++) begin : g_bcol
    assign mem.b_col[k] = ram_b[k][mem.rd_j];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) ram_result[r] <= '0;
    end else if (mem.clr) begin
      for (int r = 0; r < N; r++) ram_result[r] <= '0;
    end else if (mem.wr_en) begin
      ram_result[mem.wr_i][mem.wr_j] <= mem.wr_data;
    end
  end
endmodule

module pe_top #(
  parameter int DW     = 32,
  parameter int N      = 4,
  parameter int IDEPTH = 32,
  parameter int IW     = 16
) (
  input  logic clk,
  input  logic rstn,
  output logic stop
);
  localparam int AW  = $clog2(IDEPTH);
  localparam int IXW = $clog2(N);

  localparam logic [3:0] OP_DOT    = 4'h1;
  localparam logic [3:0] OP_MATMUL = 4'h2;
  localparam logic [3:0] OP_CLR    = 4'h3;
  localparam logic [3:0] OP_HALT   = 4'hF;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALTED} state_t;

  state_t               state;
  logic [AW-1:0]        pc;
  logic [IW-1:0]        inst_q;
  logic [3:0]           op;
  logic [IXW-1:0]       ri;
  logic [IXW-1:0]       cj;
  logic [N-1:0][DW-1:0] prod;
  logic [N-1:0][DW-1:0] prod_q;
  logic [DW-1:0]        sum;
  logic [DW-1:0]        sum_q;
  logic                 unused_ok;

  pe_top_if #(.DW(DW), .N(N), .IDEPTH(IDEPTH), .IW(IW)) mem ();

  pe_fetch #(.DW(DW), .N(N), .IDEPTH(IDEPTH), .IW(IW)) fetch_unit (
    .clk (clk),
    .rst (rstn),
    .mem (mem)
  );

  for (genvar g = 0; g < N; g++) begin : g_lane
    pe_lane #(.DW(DW)) u_lane (
      .a (mem.a_row[g]),
      .b (mem.b_col[g]),
      .p (prod[g])
    );
  end

  // Binary adder tree: leaves at t[N..2N-1], root at t[1]; N must be a power of two.
  always_comb begin
    logic [DW-1:0] t [1:2*N-1];
    for (int k = 0; k < N; k++) t[N+k] = prod[k];
    for (int n = N-1; n >= 1; n--) t[n] = t[2*n] + t[2*n+1];
    sum = t[1];
  end

  assign op        = inst_q[15:12];
  assign unused_ok = ^{inst_q[7:0], prod_q};

  assign mem.pc      = pc;
  assign mem.rd_i    = ri;
  assign mem.rd_j    = cj;
  assign mem.wr_i    = ri;
  assign mem.wr_j    = cj;
  assign mem.wr_data = sum_q;
  assign mem.wr_en   = (state == WB) && (op == OP_DOT || op == OP_MATMUL);
  assign mem.clr     = (state == WB) && (op == OP_CLR);

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state  <= FETCH;
      pc     <= '0;
      stop   <= 1'b0;
      inst_q <= '0;
      ri     <= '0;
      cj     <= '0;
      prod_q <= '0;
      sum_q  <= '0;
    end else begin
      case (state)
        FETCH: begin
          inst_q <= mem.inst;
          ri     <= mem.inst[11:10];
          cj     <= mem.inst[9:8];
          state  <= DECODE;
        end
        DECODE: begin
          case (op)
            OP_DOT:    state <= EXEC;
            OP_MATMUL: begin
              ri    <= '0;
              cj    <= '0;
              state <= EXEC;
            end
            OP_HALT: begin
              stop  <= 1'b1;
              state <= HALTED;
            end
            default:   state <= WB;
          endcase
        end
        EXEC: begin
          prod_q <= prod;
          sum_q  <= sum;
          state  <= WB;
        end
        WB: begin
          // MATMUL walks (i,j) row-major; the last element is all-ones indices.
          if (op == OP_MATMUL && !(&{ri, cj})) begin
            cj <= cj + 1'b1;
            if (&cj) ri <= ri + 1'b1;
            state <= EXEC;
          end else begin
            pc    <= pc + 1'b1;
            state <= FETCH;
          end
        end
        HALTED:  state <= HALTED;
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_top.sv
// Directed bench for pe_top: preloads memories by path, runs short programs
// and checks stop timing and result-matrix contents against hand-computed values.
module tb_pe_top;
  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic stop;
  int vectors     = 0;
  int miscompares = 0;

  pe_top dut (.clk(clk), .rstn(rstn), .stop(stop));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mode 0: all ones; 1: A identity, B=4i+j; 2: all 0x8000_0000
  task automatic load_ab(input int mode);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        case (mode)
          0: begin
            dut.fetch_unit.ram_a[i][j] = 32'd1;
            dut.fetch_unit.ram_b[i][j] = 32'd1;
          end
          1: begin
            dut.fetch_unit.ram_a[i][j] = (i == j) ? 32'd1 : 32'd0;
            dut.fetch_unit.ram_b[i][j] = 32'(4*i + j);
          end
          default: begin
            dut.fetch_unit.ram_a[i][j] = 32'h8000_0000;
            dut.fetch_unit.ram_b[i][j] = 32'h8000_0000;
          end
        endcase
      end
  endtask

  task automatic load_prog(input logic [15:0] p0, input logic [15:0] p1,
                           input logic [15:0] p2, input logic [15:0] p3);
    for (int a = 0; a < 32; a++) dut.fetch_unit.ram_inst[a] = 16'hF000;
    dut.fetch_unit.ram_inst[0] = p0;
    dut.fetch_unit.ram_inst[1] = p1;
    dut.fetch_unit.ram_inst[2] = p2;
    dut.fetch_unit.ram_inst[3] = p3;
  endtask

  // kind 0: all 4; 1: 4i+j; 2: all 0; 3: only [2][1]=4
  function automatic logic [31:0] exp_el(input int kind, input int i, input int j);
    case (kind)
      0:       return 32'd4;
      1:       return 32'(4*i + j);
      3:       return (i == 2 && j == 1) ? 32'd4 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_res(input string tag, input int kind);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("%s[%0d][%0d]", tag, i, j),
            dut.fetch_unit.ram_result[i][j], exp_el(kind, i, j));
  endtask

  // Pulse reset for one cycle, leaving rstn low at a falling edge.
  task automatic restart();
    rstn = 1'b1;
    step(1);
    rstn = 1'b0;
  endtask

  initial begin
    // reset state
    load_ab(0);
    load_prog(16'h2000, 16'hF000, 16'hF000, 16'hF000);
    step(2);
    chk("rst_stop", {31'd0, stop}, 32'd0);
    chk("rst_res11", dut.fetch_unit.ram_result[1][1], 32'd0);

    // all-ones MATMUL: 34 cycles + 2 for HALT
    rstn = 1'b0;
    step(35);
    chk("mm1_stop_early", {31'd0, stop}, 32'd0);
    step(1);
    chk("mm1_stop", {31'd0, stop}, 32'd1);
    check_res("mm1", 0);
    step(5);
    chk("mm1_stop_held", {31'd0, stop}, 32'd1);

    // identity x B
    rstn = 1'b1;
    step(1);
    chk("rst2_stop", {31'd0, stop}, 32'd0);
    chk("rst2_res23", dut.fetch_unit.ram_result[2][3], 32'd0);
    load_ab(1);
    rstn = 1'b0;
    step(36);
    chk("mm2_stop", {31'd0, stop}, 32'd1);
    check_res("mm2", 1);

    // single DOT i=2 j=1: 4 + 2 cycles
    load_ab(0);
    load_prog(16'h1900, 16'hF000, 16'hF000, 16'hF000);
    restart();
    step(5);
    chk("dot_stop_early", {31'd0, stop}, 32'd0);
    step(1);
    chk("dot_stop", {31'd0, stop}, 32'd1);
    check_res("dot", 3);

    // products of 2^31 wrap to zero
    load_ab(2);
    load_prog(16'h2000, 16'hF000, 16'hF000, 16'hF000);
    restart();
    step(36);
    chk("wrap_stop", {31'd0, stop}, 32'd1);
    check_res("wrap", 2);

    // reset in the middle of MATMUL, then rerun
    load_ab(0);
    restart();
    step(10);
    chk("mid_res03", dut.fetch_unit.ram_result[0][3], 32'd4);
    chk("mid_res10", dut.fetch_unit.ram_result[1][0], 32'd0);
    chk("mid_stop", {31'd0, stop}, 32'd0);
    rstn = 1'b1;
    #1;
    chk("mid_rst_res00", dut.fetch_unit.ram_result[0][0], 32'd0);
    chk("mid_rst_stop", {31'd0, stop}, 32'd0);
    step(1);
    rstn = 1'b0;
    step(35);
    chk("rerun_stop_early", {31'd0, stop}, 32'd0);
    step(1);
    chk("rerun_stop", {31'd0, stop}, 32'd1);
    check_res("rerun", 0);

    // MATMUL, unknown opcode, CLR, HALT
    load_prog(16'h2000, 16'h7000, 16'h3000, 16'hF000);
    restart();
    step(37);
    chk("unk_res12", dut.fetch_unit.ram_result[1][2], 32'd4);
    chk("unk_stop", {31'd0, stop}, 32'd0);
    step(3);
    chk("clr_res12", dut.fetch_unit.ram_result[1][2], 32'd0);
    chk("clr_stop", {31'd0, stop}, 32'd0);
    step(2);
    chk("clr_halt_stop", {31'd0, stop}, 32'd1);
    for (int c = 0; c < 20; c++) begin
      step(1);
      chk($sformatf("halt_hold_%0d", c), {31'd0, stop}, 32'd1);
    end
    check_res("clr", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
